// File: rtl/hawk_struct_arb.sv
// Round-robin arbiter that serialises one-struct read/write requests from
// NUM_REQ requesters onto a single struct port, returning data and a done pulse.
module hawk_struct_arb #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned STRUCT_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH     = 64 - STRUCT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*STRUCT_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [STRUCT_WIDTH-1:0]          req_rdata,
    output logic                             port_r_valid,
    output logic [ADDR_WIDTH-1:0]            port_ra,
    input  logic [STRUCT_WIDTH-1:0]          port_rd,
    input  logic                             port_r_ready,
    output logic                             port_w_valid,
    output logic [ADDR_WIDTH-1:0]            port_wa,
    output logic [STRUCT_WIDTH-1:0]          port_wd,
    input  logic                             port_w_ready,
    input  logic                             port_r_error,
    input  logic                             port_w_error,
    output logic                             err_o,
    output logic                             timeout_o,
    output logic                             busy_o,
    output logic [$clog2(NUM_REQ)-1:0]       grant_o
);

    localparam int unsigned GRANT_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [GRANT_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]      grant_q, grant_d;
    logic                    mask_q;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [STRUCT_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [STRUCT_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [NUM_REQ-1:0]      done_d;
    logic [NUM_REQ-1:0]      eligible;
    logic                    win_found;
    logic [GRANT_W-1:0]      win_idx;

    // Round-robin search from rr_ptr; the just-completed requester sits out one cycle
    always_comb begin
        int unsigned idx;
        idx       = 0;
        eligible  = req_valid;
        win_found = 1'b0;
        win_idx   = '0;
        if (mask_q) begin
            eligible[grant_q] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && eligible[GRANT_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = GRANT_W'(idx);
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
        done_d      = '0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d     = win_idx;
                    cmd_addr_d  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_wdata_d = req_wdata[win_idx*STRUCT_WIDTH +: STRUCT_WIDTH];
                    state_d     = req_we[win_idx] ? WR_BUSY : RD_BUSY;
                    rr_ptr_d    = (win_idx == GRANT_W'(NUM_REQ - 1)) ? '0
                                                                     : win_idx + GRANT_W'(1);
                    wd_cnt_d    = '0;
                end
            end
            RD_BUSY: begin
                if (port_r_ready) begin
                    rdata_d         = port_rd;
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end
            end
            WR_BUSY: begin
                if (port_w_ready) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog only observes; an AXI transfer cannot be abandoned
        if ((state_q == RD_BUSY) || (state_q == WR_BUSY)) begin
            if (wd_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
            if (wd_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            mask_q       <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rdata_q      <= '0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            req_done     <= '0;
            port_r_valid <= 1'b0;
            port_w_valid <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            mask_q       <= (state_q == DONE);
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rdata_q      <= rdata_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            req_done     <= done_d;
            port_r_valid <= (state_d == RD_BUSY);
            port_w_valid <= (state_d == WR_BUSY);
            busy_o       <= (state_d != IDLE);
        end
    end

    assign port_ra   = cmd_addr_q;
    assign port_wa   = cmd_addr_q;
    assign port_wd   = cmd_wdata_q;
    assign req_rdata = rdata_q;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;
    assign err_o     = port_r_error | port_w_error;

endmodule

// File: tb/tb_hawk_struct_arb.sv
// Randomised bench for hawk_struct_arb: requester agents and a port responder
// drive the DUT while a transaction-level model predicts every output.
module tb_hawk_struct_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 8;
    localparam int unsigned AW = 64 - SW;
    localparam int unsigned TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid, req_we, req_done;
    logic [N*AW-1:0] req_addr;
    logic [N*SW-1:0] req_wdata;
    logic [SW-1:0]   req_rdata, port_rd, port_wd;
    logic            port_r_valid, port_r_ready, port_w_valid, port_w_ready;
    logic            port_r_error, port_w_error, err_o, timeout_o, busy_o;
    logic [AW-1:0]   port_ra, port_wa;
    logic [1:0]      grant_o;

    hawk_struct_arb #(
        .NUM_REQ(N), .STRUCT_WIDTH(SW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata),
        .port_r_valid(port_r_valid), .port_ra(port_ra), .port_rd(port_rd), .port_r_ready(port_r_ready),
        .port_w_valid(port_w_valid), .port_wa(port_wa), .port_wd(port_wd), .port_w_ready(port_w_ready),
        .port_r_error(port_r_error), .port_w_error(port_w_error),
        .err_o(err_o), .timeout_o(timeout_o), .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Requester agents
    bit            a_valid[N];
    bit            a_req[N];
    bit            a_hold[N];
    int            a_wait[N];
    bit            a_we[N];
    logic [AW-1:0] a_addr[N];
    logic [SW-1:0] a_wdata[N];

    // Transaction-level reference model
    bit            act, done_now, done_pend, m_we, m_timeout, long_ok;
    int            m_cur, m_rr, m_grant, m_lat, busy_cnt, last_done, n_long;
    logic [AW-1:0] m_addr;
    logic [SW-1:0] m_wdata, m_rdata;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = a_valid[i];
            req_we[i]              = a_we[i];
            req_addr[i*AW +: AW]   = a_addr[i];
            req_wdata[i*SW +: SW]  = a_wdata[i];
        end
    endtask

    task automatic model_reset();
        act = 0; done_now = 0; done_pend = 0; m_we = 0; m_timeout = 0;
        m_cur = 0; m_rr = 0; m_grant = 0; m_lat = 1; busy_cnt = 0; last_done = -1;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int i = 0; i < N; i++) begin
            a_valid[i] = 0; a_req[i] = 0; a_hold[i] = 0; a_wait[i] = int'($urandom % 4);
            a_we[i] = 0; a_addr[i] = '0; a_wdata[i] = '0;
        end
        port_r_ready = 0; port_w_ready = 0; port_rd = '0;
        port_r_error = 0; port_w_error = 0;
        drive_inputs();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"},    busy_o,       0);
        check_eq({pfx, "_rvalid"},  port_r_valid, 0);
        check_eq({pfx, "_wvalid"},  port_w_valid, 0);
        check_eq({pfx, "_done"},    req_done,     0);
        check_eq({pfx, "_grant"},   grant_o,      0);
        check_eq({pfx, "_rdata"},   req_rdata,    0);
        check_eq({pfx, "_timeout"}, timeout_o,    0);
        check_eq({pfx, "_ra"},      port_ra,      0);
        check_eq({pfx, "_wa"},      port_wa,      0);
        check_eq({pfx, "_wd"},      port_wd,      0);
    endtask

    // One clock cycle: compare outputs against the model, then drive this cycle's inputs
    task automatic step();
        int w;
        @(posedge clk_i);
        #1;
        cyc++;
        check_eq("busy",    busy_o,       64'(act || done_now));
        check_eq("rvalid",  port_r_valid, 64'(act && !m_we));
        check_eq("wvalid",  port_w_valid, 64'(act && m_we));
        check_eq("done",    req_done,     done_now ? (64'd1 << m_cur) : 64'd0);
        check_eq("grant",   grant_o,      64'(m_grant));
        check_eq("rdata",   req_rdata,    64'(m_rdata));
        check_eq("timeout", timeout_o,    64'(m_timeout));
        if (act) begin
            check_eq("addr", m_we ? port_wa : port_ra, 64'(m_addr));
            if (m_we) check_eq("wdata", port_wd, 64'(m_wdata));
        end

        for (int i = 0; i < N; i++) begin
            if (done_now && i == m_cur) begin
                a_req[i]   = 0;
                a_hold[i]  = ($urandom % 3) == 0;
                a_valid[i] = a_hold[i];
                a_wait[i]  = int'($urandom % 4);
            end else if (a_hold[i]) begin
                a_valid[i] = 1;
                a_hold[i]  = 0;
            end else if (a_req[i]) begin
                if (act && i == m_cur && ($urandom % 8) == 0) a_valid[i] = 0;
            end else if (a_wait[i] == 0) begin
                a_req[i]   = 1;
                a_valid[i] = 1;
                a_we[i]    = $urandom % 2;
                a_addr[i]  = AW'({$urandom, $urandom});
                a_wdata[i] = SW'($urandom);
            end else begin
                a_wait[i]--;
                a_valid[i] = 0;
            end
        end

        port_r_ready = 0;
        port_w_ready = 0;
        port_rd      = SW'($urandom);
        if (act) begin
            busy_cnt++;
            if (busy_cnt >= TO) m_timeout = 1;
            if (busy_cnt == m_lat) begin
                if (m_we) port_w_ready = 1;
                else begin
                    port_r_ready = 1;
                    m_rdata      = port_rd;
                end
                act       = 0;
                done_pend = 1;
            end
        end else if (done_now) begin
            done_now  = 0;
            last_done = m_cur;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (w < 0 && a_valid[j] && j != last_done) w = j;
            end
            last_done = -1;
            if (w >= 0) begin
                act      = 1;
                m_cur    = w;
                m_grant  = w;
                m_we     = a_we[w];
                m_addr   = a_addr[w];
                m_wdata  = a_wdata[w];
                m_rr     = (w + 1) % N;
                busy_cnt = 0;
                if (long_ok && (n_long < 2 || ($urandom % 8) == 0)) begin
                    n_long++;
                    m_lat = (n_long == 1) ? 15 : (n_long == 2) ? 16 : 15 + int'($urandom % 6);
                end else begin
                    m_lat = 1 + int'($urandom % 5);
                end
            end
        end
        if (done_pend) begin
            done_now  = 1;
            done_pend = 0;
        end

        drive_inputs();
        port_r_error = ($urandom % 16) == 0;
        port_w_error = ($urandom % 16) == 0;
        #1;
        check_eq("err", err_o, 64'(port_r_error | port_w_error));
    endtask

    initial begin
        bit found;
        rst_ni  = 0;
        long_ok = 0;
        n_long  = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        #3 rst_ni = 1;

        repeat (1500) step();
        long_ok = 1;
        repeat (1500) step();

        // Pull reset while a write is on the port
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (act && m_we) found = 1;
        end
        check_eq("wr_found", 64'(found), 1);
        @(posedge clk_i);
        #4 rst_ni = 0;
        #1;
        check_reset_outputs("async_rst");
        long_ok = 0;
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_ni = 1;
        repeat (400) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
